// File: rtl/uart_boot_loader.sv
// Purpose: receive a program over UART and write it word-by-word into instruction memory while holding the core in reset.
// Latency: the write strobe comes 1 cycle after the 4th byte of a word; hold/done change 1 cycle after the last strobe.
// Backpressure: none; memory accepts a word every cycle, and words arrive at most once per 40 bit-times.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10,
  parameter int MAX_WORDS    = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_hold_o,
  output logic              load_done_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_N     = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

  // ---------------- receiver ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             stop_err;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state register and datapath.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  // Receiver next state: mid-start check rejects glitches, then 8 LSB-first samples and a stop check.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    stop_err   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d      = '0;
            rx_state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_vld_d = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_t   ld_state_q, ld_state_d;
  logic [15:0] len_q;
  logic [15:0] widx_q;
  logic [1:0]  lane_q;
  logic [23:0] buf_q;
  logic        store_lo, store_hi, lane_store, wr_fire, enter_err;
  logic [15:0] n_word;
  logic        we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q;
  logic        done_q;
  logic        err_q;

  assign n_word = {shift_q, len_q[7:0]};

  // Loader state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ld_state_q <= LD_LEN_LO;
    end else begin
      ld_state_q <= ld_state_d;
    end
  end

  // Loader next state: count bytes, then gather 4 bytes per word; DONE and ERR are terminal.
  always_comb begin
    ld_state_d = ld_state_q;
    store_lo   = 1'b0;
    store_hi   = 1'b0;
    lane_store = 1'b0;
    wr_fire    = 1'b0;
    enter_err  = 1'b0;
    unique case (ld_state_q)
      LD_LEN_LO: begin
        if (byte_vld_q) begin
          store_lo   = 1'b1;
          ld_state_d = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (byte_vld_q) begin
          store_hi = 1'b1;
          if (n_word == 16'd0) begin
            ld_state_d = LD_DONE;
          end else if ({1'b0, n_word} > MAX_N) begin
            enter_err  = 1'b1;
            ld_state_d = LD_ERR;
          end else begin
            ld_state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (byte_vld_q) begin
          if (lane_q == 2'd3) begin
            wr_fire = 1'b1;
            if (widx_q + 16'd1 == len_q) begin
              ld_state_d = LD_DONE;
            end
          end else begin
            lane_store = 1'b1;
          end
        end
      end
      LD_DONE: ld_state_d = LD_DONE;
      LD_ERR:  ld_state_d = LD_ERR;
      default: ld_state_d = LD_LEN_LO;
    endcase
  end

  // Loader datapath: count, byte lanes, word index and the registered memory write port.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      len_q  <= '0;
      widx_q <= '0;
      lane_q <= '0;
      buf_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= wr_fire;
      if (store_lo) begin
        len_q[7:0] <= shift_q;
      end
      if (store_hi) begin
        len_q[15:8] <= shift_q;
      end
      if (lane_store) begin
        buf_q  <= {shift_q, buf_q[23:8]};
        lane_q <= lane_q + 2'd1;
      end
      if (wr_fire) begin
        lane_q <= '0;
        data_q <= {shift_q, buf_q};
        addr_q <= widx_q[ADDR_W-1:0];
        widx_q <= widx_q + 16'd1;
      end
    end
  end

  // Status flags: release follows DONE by one cycle so it trails the last strobe; errors are sticky.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (ld_state_q == LD_DONE);
      err_q  <= err_q | stop_err | enter_err;
    end
  end

  assign imem_we_o   = we_q;
  assign imem_addr_o = addr_q;
  assign imem_data_o = data_q;
  assign cpu_hold_o  = ~done_q;
  assign load_done_o = done_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int MW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          cpu_hold;
  logic          load_done;
  logic          frame_err;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .MAX_WORDS   (MW)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst_n),
    .rx_i       (rx),
    .imem_we_o  (imem_we),
    .imem_addr_o(imem_addr),
    .imem_data_o(imem_data),
    .cpu_hold_o (cpu_hold),
    .load_done_o(load_done),
    .frame_err_o(frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          hold_fall_cyc = -1;
  int          done_rise_cyc = -1;
  logic        hold_prev = 1'b1;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and edge monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_data);
      wr_cyc.push_back(cyc);
    end
    if (hold_prev === 1'b1 && cpu_hold === 1'b0) hold_fall_cyc = cyc;
    if (done_prev === 1'b0 && load_done === 1'b1) done_rise_cyc = cyc;
    hold_prev = cpu_hold;
    done_prev = load_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    if (i < wr_addr.size()) return wr_addr[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] wd(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int wc(input int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return -1000;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_we",   32'(imem_we),   32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_data", imem_data,      32'd0);
    check("rst_hold", 32'(cpu_hold),  32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err",  32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two words
    base = wr_addr.size();
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1);
    check("t1_hold_mid", 32'(cpu_hold), 32'd1);
    send_byte(8'h12, 1'b1);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    settle();
    check("t1_nwr",   32'(wr_addr.size() - base), 32'd2);
    check("t1_a0",    wa(base),     32'd0);
    check("t1_d0",    wd(base),     32'h1234_5678);
    check("t1_a1",    wa(base + 1), 32'd1);
    check("t1_d1",    wd(base + 1), 32'hDEAD_BEEF);
    check("t1_hold_lat", 32'(hold_fall_cyc - wc(base + 1)), 32'd1);
    check("t1_done_lat", 32'(done_rise_cyc - wc(base + 1)), 32'd1);
    check("t1_hold",  32'(cpu_hold),  32'd0);
    check("t1_done",  32'(load_done), 32'd1);
    check("t1_err",   32'(frame_err), 32'd0);

    // 6: bytes after DONE are ignored
    base = wr_addr.size();
    send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
    settle();
    check("t6_nwr",  32'(wr_addr.size() - base), 32'd0);
    check("t6_hold", 32'(cpu_hold),  32'd0);
    check("t6_done", 32'(load_done), 32'd1);
    check("t6_err",  32'(frame_err), 32'd0);
    check("t6_addr", 32'(imem_addr), 32'd1);
    check("t6_data", imem_data,      32'hDEAD_BEEF);

    // 2: zero-length program
    do_reset();
    base = wr_addr.size();
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    settle();
    check("t2_nwr",  32'(wr_addr.size() - base), 32'd0);
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_hold", 32'(cpu_hold),  32'd0);
    check("t2_err",  32'(frame_err), 32'd0);

    // 3: count above MAX_WORDS
    do_reset();
    base = wr_addr.size();
    send_byte(8'h09, 1'b1); send_byte(8'h00, 1'b1);
    settle();
    check("t3_err",  32'(frame_err), 32'd1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    settle();
    check("t3_nwr",  32'(wr_addr.size() - base), 32'd0);
    check("t3_hold", 32'(cpu_hold),  32'd1);
    check("t3_done", 32'(load_done), 32'd0);
    check("t3_err2", 32'(frame_err), 32'd1);

    // 4: glitch and bad stop bit inside DATA
    do_reset();
    base = wr_addr.size();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    #1;
    check("t4_glitch_err", 32'(frame_err), 32'd0);
    send_byte(8'hA5, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    #1;
    check("t4_stop_err", 32'(frame_err), 32'd1);
    check("t4_nwr_mid",  32'(wr_addr.size() - base), 32'd0);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    settle();
    check("t4_nwr",  32'(wr_addr.size() - base), 32'd1);
    check("t4_a0",   wa(base), 32'd0);
    check("t4_d0",   wd(base), 32'h0403_0201);
    check("t4_done", 32'(load_done), 32'd1);

    // 5: reset mid-word discards the partial load
    do_reset();
    base = wr_addr.size();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_hold_rst", 32'(cpu_hold), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t5_hold_post", 32'(cpu_hold), 32'd1);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1);
    #1;
    check("t5_hold_mid", 32'(cpu_hold), 32'd1);
    send_byte(8'hDD, 1'b1);
    settle();
    check("t5_nwr",  32'(wr_addr.size() - base), 32'd1);
    check("t5_a0",   wa(base), 32'd0);
    check("t5_d0",   wd(base), 32'hDDCC_BBAA);
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_hold", 32'(cpu_hold),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
